// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter for the ALU and load-unit ports of RegFile_32, plus the pending-destination scoreboard.
// Ties are granted round-robin. The write port is registered, so a write appears one cycle after its grant.

module rf_sb_cell (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic q
);
  // If a register is issued and written back on the same edge, the bit stays set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end
endmodule

module regfile_wb_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_idx,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [IDX_W-1:0]  mem_idx,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              iss_en,
  input  logic [IDX_W-1:0]  iss_idx,
  input  logic [IDX_W-1:0]  chk1_idx,
  input  logic [IDX_W-1:0]  chk2_idx,
  output logic              stall,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic [NUM_REGS-1:0] busy
);
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  logic              last_gnt;
  logic              xfer;
  logic [IDX_W-1:0]  x_idx;
  logic [DATA_W-1:0] x_data;
  logic              x_nz;

  // Reset gates ready directly, so nothing is accepted while reset is low.
  always_comb begin
    alu_ready = reset & alu_valid & (~mem_valid | (last_gnt == GNT_MEM));
    mem_ready = reset & mem_valid & (~alu_valid | (last_gnt == GNT_ALU));
  end

  assign xfer   = alu_ready | mem_ready;
  assign x_idx  = alu_ready ? alu_idx  : mem_idx;
  assign x_data = alu_ready ? alu_data : mem_data;
  assign x_nz   = xfer & (x_idx != '0);

  // The grant pointer advances on every transfer, including writes to r0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         last_gnt <= GNT_MEM;
    else if (alu_ready) last_gnt <= GNT_ALU;
    else if (mem_ready) last_gnt <= GNT_MEM;
  end

  // wr_idx and wr_data keep their last values when no write is driven.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= x_nz;
      if (x_nz) begin
        wr_idx  <= x_idx;
        wr_data <= x_data;
      end
    end
  end

  assign busy[0] = 1'b0;

  // r0 is never marked pending.
  for (genvar n = 1; n < NUM_REGS; n++) begin : g_sb
    rf_sb_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .set   (iss_en & (iss_idx == IDX_W'(n))),
      .clr   (x_nz & (x_idx == IDX_W'(n))),
      .q     (busy[n])
    );
  end

  // stall reads only the registered scoreboard. A writeback in this cycle is not forwarded.
  assign stall = busy[chk1_idx] | busy[chk2_idx];

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-003 SHALL have port: alu_valid  input  1  ALU writeback request.
REQ-004 SHALL have port: alu_idx  input  5  ALU destination register.
REQ-005 SHALL have port: alu_data  input  32  ALU result.
REQ-006 SHALL have port: alu_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have port: mem_valid / mem_idx / mem_data / mem_ready  in / in / in / out  1 / 5 / 32 / 1  load-unit writeback, same meaning as ALU set.
REQ-008 SHALL have port: iss_en  input  1  instruction issue; marks destination pending.
REQ-009 SHALL have port: iss_idx  input  5  issued destination register.
REQ-010 SHALL have port: chk1_idx, chk2_idx  input  5 each  source registers of next instruction.
REQ-011 SHALL have port: stall  output  1  a source register is pending.
REQ-012 SHALL have port: wr_en / wr_idx / wr_data  output  1 / 5 / 32  drive RegFile_32 write port.
REQ-013 SHALL have port: busy  output  32  scoreboard, bit n = register n pending.

Function
REQ-014 SHALL grant at most one requester per cycle; transfer occurs when valid and ready both high at a rising edge.
REQ-015 SHALL compute alu_ready/mem_ready combinationally from the valid inputs and the last-grant pointer; ready never asserts without the matching valid.
REQ-016 SHALL, when only one requester is valid, grant it.
REQ-017 SHALL, when both are valid, grant the requester not granted last; the pointer updates only on a transfer.
REQ-018 SHALL require requesters to hold valid/idx/data stable until ready; the block does not buffer ungranted requests.
REQ-019 SHALL register the write: a transfer at edge N drives wr_en=1, wr_idx, wr_data for exactly the cycle after edge N (latency 1); otherwise wr_en=0.
REQ-020 SHALL accept a transfer with idx=0 (ready high, pointer advances) but keep wr_en=0 for it.
REQ-021 SHALL hold wr_idx/wr_data at their last values when wr_en=0.
REQ-022 SHALL set busy[iss_idx] at the edge where iss_en=1 and iss_idx!=0; busy[0] is constant 0.
REQ-023 SHALL clear busy[idx] at the edge of a transfer with idx!=0.
REQ-024 SHALL, on set and clear of the same index at one edge, leave the bit set (newer issue wins).
REQ-025 SHALL perform a writeback to a non-busy register normally; busy is unchanged.
REQ-026 SHALL drive stall = busy[chk1_idx] | busy[chk2_idx], combinational from the registered busy; index 0 never stalls.
REQ-027 SHALL NOT forward same-cycle transfers into stall; a register cleared at edge N stops stalling from cycle N onward.

Reset
REQ-028 SHALL, while reset=0, asynchronously force busy=0, wr_en=0, wr_idx=0, wr_data=0, last-grant pointer = MEM (ALU wins next tie), and alu_ready=mem_ready=0.
REQ-029 SHALL drop any transfer or issue coincident with reset assertion; no write follows release.
REQ-030 SHALL resume arbitration on the first rising edge after reset returns to 1.

Verification
REQ-031 Reset release, both valid, alu_idx=3/0x5, mem_idx=4/0xA: cycle 1 ALU granted and wr(3,0x5) next cycle; cycle 2 MEM granted and wr(4,0xA).
REQ-032 Both valid continuously for 4 cycles: grants alternate ALU, MEM, ALU, MEM, and wr_en is high for 4 consecutive cycles.
REQ-033 iss_en idx=7, then chk1_idx=7: stall=1 until the ALU writes idx 7, then stall=0 on the cycle after the edge and busy[7]=0.
REQ-034 iss_en idx=9 and an ALU transfer to idx 9 on the same edge: busy[9]=1 afterwards; stall remains for chk2_idx=9.
REQ-035 MEM transfer idx=0 data 0xFFFFFFFF: mem_ready=1, wr_en stays 0, busy unchanged; iss_en idx=0 leaves busy[0]=0.
REQ-036 reset pulled low mid-cycle with busy=0x00000280 and a pending grant: busy=0, wr_en=0, ready=0 immediately; no write after release.
